// File: rtl/conv_pkg.sv
// Shared helpers for the convolution window datapath.
// Width helpers, counter sizing and per-frame window math.
package conv_pkg;

    // Window side values supported by the conv calculator.
    function automatic bit kernel_legal(input int k);
        return (k == 1) || (k == 3) || (k == 5) || (k == 7);
    endfunction

    // Flattened window width in bits.
    function automatic int win_width(input int k, input int n);
        return k * k * n;
    endfunction

    // Position counter width; never narrower than one bit.
    function automatic int ctr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Width of a counter that must reach w*h inclusive.
    function automatic int win_cnt_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    // Valid (unpadded) window positions in one frame.
    function automatic int windows_per_frame(input int k, input int w,
                                             input int h);
        return (w - k + 1) * (h - k + 1);
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image-row delay line for the window generator.
// Advances only on accepted pixels; contents are not reset.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int N     = 4
) (
    input  logic         clk_i,
    input  logic         en_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] dout_o
);

    logic [DEPTH-1:0][N-1:0] mem_q;

    // Shift the row by one pixel on every accepted input.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK window generator feeding the conv calculator.
// Optional win_cnt/frame_done outputs under CONV_WIN_CNT_EN.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 pix_in,
    input  logic                         pix_valid,
    input  logic                         sof,
    output logic [KERNEL*KERNEL*N-1:0]   data2conv,
    output logic                         en_out
`ifdef CONV_WIN_CNT_EN
    ,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0] win_cnt,
    output logic                         frame_done
`endif
);

    localparam int CW  = ctr_width(IMG_W);
    localparam int RW  = ctr_width(IMG_H);
    localparam int WW  = win_width(KERNEL, N);
    localparam int KM1 = KERNEL - 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KM1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KM1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          en_q, en_d;
    logic          win_fire;

    logic [KERNEL-1:0][N-1:0]              col_new;
    logic [KERNEL-1:0][KERNEL-1:0][N-1:0]  win_q, win_d;

    // Position of the pixel on the bus; sof forces it to the origin.
    always_comb begin
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // A window completes when the pixel closes a full KxK region
    // inside the current row span, so rows never wrap into one window.
    always_comb begin
        win_fire = pix_valid && (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);
        en_d     = win_fire;
    end

    // Right-hand column: current pixel at the bottom, row taps above.
    assign col_new[KERNEL-1] = pix_in;

    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
        conv_line_buf #(
            .DEPTH (IMG_W),
            .N     (N)
        ) u_lb (
            .clk_i  (clk),
            .en_i   (pix_valid),
            .din_i  (col_new[KERNEL-1-j]),
            .dout_o (col_new[KERNEL-2-j])
        );
    end

    // Shift the window one column left and load the new column.
    always_comb begin
        win_d = win_q;
        if (pix_valid) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERNEL-1] = col_new[r];
            end
        end
    end

    // Position, window and enable state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            en_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            en_q  <= en_d;
        end
    end

    // Packed [r][c] order places element r*KERNEL+c at that N-bit slot.
    assign data2conv = WW'(win_q);
    assign en_out    = en_q;

`ifdef CONV_WIN_CNT_EN
    localparam int WCW = win_cnt_width(IMG_W, IMG_H);
    localparam logic [WCW-1:0] WPF =
        WCW'(windows_per_frame(KERNEL, IMG_W, IMG_H));

    logic [WCW-1:0] cnt_q, cnt_d;
    logic           done_q, done_d;

    // Per-frame window count; restarts on the origin pixel.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (pix_valid) begin
            if ((cur_col == '0) && (cur_row == '0)) begin
                cnt_d = '0;
            end
            if (win_fire) begin
                cnt_d = cnt_d + WCW'(1);
            end
            done_d = win_fire && (cnt_d == WPF);
        end
    end

    // Count and last-window pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign win_cnt    = cnt_q;
    assign frame_done = done_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen (KERNEL=3, 4x4 image).
// Table vectors, directed corner sequences and a random stream.
module tb_conv_window_gen;

    localparam int K  = 3;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WW = K * K * N;

    logic          clk;
    logic          rst;
    logic [N-1:0]  pix_in;
    logic          pix_valid;
    logic          sof;
    logic [WW-1:0] data2conv;
    logic          en_out;
`ifdef CONV_WIN_CNT_EN
    logic [4:0]    win_cnt;
    logic          frame_done;
`endif

    conv_window_gen #(
        .KERNEL (K),
        .N      (N),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .data2conv  (data2conv),
        .en_out     (en_out)
`ifdef CONV_WIN_CNT_EN
        ,
        .win_cnt    (win_cnt),
        .frame_done (frame_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int errs = 0;
    int pulses = 0;

    // Reference model: the frame as a 2-D image plus raster position.
    logic [N-1:0]  img [H][W];
    int            mr, mc;
    bit            exp_en;
    bit            win_known;
    logic [WW-1:0] exp_win;
    int            exp_cnt;
    bit            exp_fd;

    typedef struct {
        logic          v;
        logic          s;
        logic [N-1:0]  p;
        logic          en;
        logic [WW-1:0] win;
    } vec_t;

    vec_t tbl [16];

    task automatic cmp(input string name, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic v, input logic s,
                                input logic [N-1:0] p);
        int pr, pc;
        if (!rst) begin
            mr = 0; mc = 0;
            exp_en = 0; exp_fd = 0; exp_cnt = 0;
            exp_win = '0; win_known = 1;
        end else if (v) begin
            if (s) begin
                mr = 0; mc = 0;
            end
            pr = mr; pc = mc;
            img[pr][pc] = p;
            if (pr == 0 && pc == 0) exp_cnt = 0;
            exp_en = (pr >= K - 1) && (pc >= K - 1);
            exp_fd = 0;
            win_known = 0;
            if (exp_en) begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        exp_win[(r*K+c)*N +: N] = img[pr-K+1+r][pc-K+1+c];
                win_known = 1;
                exp_cnt++;
                exp_fd = (pr == H - 1) && (pc == W - 1);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
                if (mr == H) mr = 0;
            end
        end else begin
            exp_en = 0;
            exp_fd = 0;
        end
    endtask

    task automatic check_model();
        cmp("en_out", WW'(en_out), WW'(exp_en));
        if (win_known) cmp("data2conv", data2conv, exp_win);
`ifdef CONV_WIN_CNT_EN
        cmp("win_cnt", WW'(win_cnt), WW'(exp_cnt));
        cmp("frame_done", WW'(frame_done), WW'(exp_fd));
`endif
    endtask

    task automatic tick(input logic v, input logic s,
                        input logic [N-1:0] p, input bit chk);
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        @(posedge clk);
        model_update(v, s, p);
        #1;
        if (en_out) pulses++;
        if (chk) check_model();
    endtask

    int first_idx;

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].s   = (i == 0);
            tbl[i].p   = 4'(i);
            tbl[i].en  = 1'b0;
            tbl[i].win = '0;
        end
        tbl[10].en = 1'b1; tbl[10].win = 36'hA98654210;
        tbl[11].en = 1'b1; tbl[11].win = 36'hBA9765321;
        tbl[14].en = 1'b1; tbl[14].win = 36'hEDCA98654;
        tbl[15].en = 1'b1; tbl[15].win = 36'hFEDBA9765;

        rst = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
        mr = 0; mc = 0; exp_en = 0; exp_fd = 0; exp_cnt = 0;
        exp_win = '0; win_known = 1;

        // Reset state.
        tick(1'b0, 1'b0, 4'h0, 1'b1);
        tick(1'b1, 1'b0, 4'h7, 1'b1);
        rst = 1'b1;

        // Continuous frame from the table, including row-boundary cells.
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].v, tbl[i].s, tbl[i].p, 1'b0);
            cmp($sformatf("tbl_en[%0d]", i), WW'(en_out), WW'(tbl[i].en));
            if (tbl[i].en)
                cmp($sformatf("tbl_win[%0d]", i), data2conv, tbl[i].win);
        end

        // Back-to-back frame without sof.
        pulses = 0;
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 4'(i), 1'b1);
        cmp("frame2_pulses", WW'(pulses), WW'(4));

        // Roughly half-duty valid gaps over two frames.
        for (int f = 0; f < 2; f++) begin
            int i;
            i = 0;
            pulses = 0;
            while (i < 16) begin
                if ($urandom_range(1, 0) == 1) begin
                    tick(1'b1, (i == 0), 4'(i), 1'b1);
                    i++;
                end else begin
                    tick(1'b0, 1'b0, 4'($urandom), 1'b1);
                end
            end
            tick(1'b0, 1'b0, 4'h0, 1'b1);
            cmp("gap_pulses", WW'(pulses), WW'(4));
        end

        // sof at pixel 6 of an in-progress frame.
        for (int i = 0; i < 6; i++) tick(1'b1, (i == 0), 4'(15 - i), 1'b1);
        pulses = 0;
        first_idx = -1;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, (i == 0), 4'(i), 1'b1);
            if (en_out && first_idx < 0) first_idx = i;
        end
        cmp("sof_first_pulse", WW'(first_idx), WW'(10));
        cmp("sof_pulses", WW'(pulses), WW'(4));

        // One-cycle reset after pixel 12.
        for (int i = 0; i < 13; i++) tick(1'b1, (i == 0), 4'(i), 1'b1);
        rst = 1'b0;
        tick(1'b1, 1'b0, 4'hD, 1'b1);
        rst = 1'b1;
        cmp("rst_en", WW'(en_out), WW'(0));
        cmp("rst_data", data2conv, '0);
        first_idx = -1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 4'(i), 1'b1);
            if (en_out && first_idx < 0) first_idx = i;
        end
        cmp("rst_first_pulse", WW'(first_idx), WW'(10));
        cmp("rst_pulses", WW'(pulses), WW'(4));

        // Random stream with random data, stalls and occasional sof.
        for (int n = 0; n < 800; n++) begin
            logic v, s;
            v = ($urandom_range(3, 0) != 0);
            s = v && ($urandom_range(19, 0) == 0);
            tick(v, s, 4'($urandom_range(15, 0)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
